// File: rtl/delay_line_scheduler.sv
// delay_line_scheduler: sequences the recirculating delay-line memory loop.
// Time is sliced into bit slots of BIT_CLKS clocks. The line output is sampled
// mid-slot and re-launched on the next slot boundary, so the loop (external line
// of BITS-1 bit times plus the one-slot line_in register) stores exactly BITS bits.
// A byte-wide request port lets the host read or overwrite 8 consecutive slots.
// Optional feature macro: DELAY_SCHED_CLEAR_EN. When defined, reset first
// zeroes the whole loop for one revolution before accepting requests.
module delay_line_scheduler #(
  parameter int unsigned CLK_FREQ     = 81_000_000,
  parameter int unsigned BIT_CLKS     = 154,
  parameter int unsigned BITS         = 576,
  parameter int unsigned SAMPLE_POINT = 77,
  parameter int unsigned ADDR_W       = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              line_out,
  output logic              line_in,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [7:0]        req_wdata,
  output logic              rsp_valid,
  output logic [7:0]        rsp_rdata,
  output logic              rsp_err,
  output logic [9:0]        bit_addr
);

  localparam int unsigned          SLOT_W      = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;
  localparam logic [SLOT_W-1:0]    SLOT_LAST   = SLOT_W'(BIT_CLKS - 1);
  localparam logic [SLOT_W-1:0]    SLOT_SAMPLE = SLOT_W'(SAMPLE_POINT);
  localparam logic [9:0]           ADDR_LAST   = 10'(BITS - 1);
  localparam int unsigned          BYTES       = BITS / 8;

  // Elaboration-time sanity check of the parameter set.
  if ((BITS % 8 != 0) || (BITS > 1024) || (SAMPLE_POINT >= BIT_CLKS) || (CLK_FREQ == 0)) begin : g_bad_params
    $error("delay_line_scheduler: inconsistent parameters");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_XFER,
    S_RESP,
    S_CLEAR
  } state_e;

`ifdef DELAY_SCHED_CLEAR_EN
  localparam state_e RESET_STATE = S_CLEAR;
`else
  localparam state_e RESET_STATE = S_IDLE;
`endif

  // Slot timing and recirculation state
  logic [SLOT_W-1:0] slot_cnt_q;
  logic [9:0]        bit_addr_q, bit_addr_d;
  logic [1:0]        sync_q;
  logic              samp_q;
  logic              line_in_q, line_in_d;
  logic              slot_wrap;

  // Request / transfer state
  state_e            state_q;
  logic              write_q;
  logic [7:0]        wdata_q;
  logic [9:0]        base_q;
  logic [2:0]        idx_q;
  logic [7:0]        rdata_q, rdata_d;
  logic              rsp_valid_q;
  logic [7:0]        rsp_rdata_q;
  logic              rsp_err_q;
  logic              addr_bad;

  assign slot_wrap  = (slot_cnt_q == SLOT_LAST);
  assign bit_addr_d = (bit_addr_q == ADDR_LAST) ? 10'd0 : bit_addr_q + 10'd1;
  assign addr_bad   = (32'(req_addr) >= BYTES);

  // Bit launched into the line for the next slot: recirculated sample unless a write or clear overrides it.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can leave it unassigned (no latch).
    line_in_d = samp_q;
    rdata_d   = rdata_q;
    rdata_d[idx_q] = line_in_q;
    case (state_q)
      S_CLEAR: if (bit_addr_q != ADDR_LAST) line_in_d = 1'b0;
      S_WAIT:  if (write_q && (bit_addr_d == base_q)) line_in_d = wdata_q[0];
      S_XFER:  if (write_q && (idx_q != 3'd7)) line_in_d = wdata_q[idx_q + 3'd1];
      default: ;
    endcase
  end

  // Slot counter, bit address, line_out synchroniser, mid-slot sample and line_in register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_cnt_q <= '0;
      bit_addr_q <= '0;
      sync_q     <= '0;
      samp_q     <= 1'b0;
      line_in_q  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
      sync_q <= {sync_q[0], line_out};
      if (slot_cnt_q == SLOT_SAMPLE) samp_q <= sync_q[1];
      if (slot_wrap) begin
        slot_cnt_q <= '0;
        bit_addr_q <= bit_addr_d;
        line_in_q  <= line_in_d;
      end else begin
        slot_cnt_q <= slot_cnt_q + SLOT_W'(1);
      end
    end
  end

  // Request FSM with registered response outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= RESET_STATE;
      write_q     <= 1'b0;
      wdata_q     <= '0;
      base_q      <= '0;
      idx_q       <= '0;
      rdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            if (addr_bad) begin
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= '0;
              state_q     <= S_RESP;
            end else begin
              write_q <= req_write;
              wdata_q <= req_wdata;
              base_q  <= 10'({req_addr, 3'b000});
              state_q <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (slot_wrap && (bit_addr_d == base_q)) begin
            idx_q   <= '0;
            rdata_q <= '0;
            state_q <= S_XFER;
          end
        end
        S_XFER: begin
          if (slot_wrap) begin
            rdata_q <= rdata_d;
            if (idx_q == 3'd7) begin
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b0;
              rsp_rdata_q <= write_q ? 8'h00 : rdata_d;
              state_q     <= S_RESP;
            end else begin
              idx_q <= idx_q + 3'd1;
            end
          end
        end
        S_RESP:  state_q <= S_IDLE;
        S_CLEAR: if (slot_wrap && (bit_addr_q == ADDR_LAST)) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign line_in   = line_in_q;
  assign bit_addr  = bit_addr_q;
  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_delay_line_scheduler.sv
// Bench for delay_line_scheduler on a scaled-down loop (64 bits, 6 clocks/slot).
// The delay line is a (BITS-1)*BIT_CLKS-cycle shift register. Requests push their
// expected response into a queue; a monitor pops and compares on each rsp_valid.
module tb_delay_line_scheduler;

  localparam int unsigned BIT_CLKS = 6;
  localparam int unsigned BITS     = 64;
  localparam int unsigned SAMPLE_P = 3;
  localparam int unsigned ADDR_W   = 4;
  localparam int unsigned REV      = BITS * BIT_CLKS;
  localparam int unsigned LINE_D   = (BITS - 1) * BIT_CLKS;
  localparam int unsigned LAT_MAX  = (BITS + 8) * BIT_CLKS + 2;

  typedef struct {
    logic [7:0] rdata;
    logic       err;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              line_out;
  logic              line_in;
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [7:0]        req_wdata;
  logic              rsp_valid;
  logic [7:0]        rsp_rdata;
  logic              rsp_err;
  logic [9:0]        bit_addr;

  logic [LINE_D-1:0] line_sr;
  exp_t              exp_q[$];
  int                n_checks = 0;
  int                n_fail   = 0;
  int                cyc      = 0;
  int                rsp_count = 0;
  int                rsp_cyc  = 0;
  int                acc_cyc  = 0;
  bit                watch    = 1'b0;
  int                ones_cnt = 0;
  int                ones_bad = 0;

  delay_line_scheduler #(
    .CLK_FREQ    (81_000_000),
    .BIT_CLKS    (BIT_CLKS),
    .BITS        (BITS),
    .SAMPLE_POINT(SAMPLE_P),
    .ADDR_W      (ADDR_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .line_out (line_out),
    .line_in  (line_in),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .bit_addr (bit_addr)
  );

  always #5 clk = ~clk;

  // Delay line model
  initial begin
`ifdef DELAY_SCHED_CLEAR_EN
    line_sr = '1;
`else
    line_sr = '0;
`endif
  end
  always @(posedge clk) line_sr <= {line_sr[LINE_D-2:0], line_in};
  assign line_out = line_sr[LINE_D-1];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every response pulse; also tracks line_in for the slot test.
  always @(posedge clk) begin
    #1;
    if (watch && line_in === 1'b1) begin
      ones_cnt++;
      if (bit_addr !== 10'd0) ones_bad++;
    end
    if (rsp_valid === 1'b1) begin
      exp_t e;
      rsp_count++;
      rsp_cyc = cyc;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_rsp: rsp_valid with no request outstanding (t=%0t)", $time);
      end else begin
        e = exp_q.pop_front();
        check("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
        check("rsp_err", 32'(rsp_err), 32'(e.err));
      end
    end
  end

  // Issue one request; pushes an expectation unless the response is meant to be aborted.
  task automatic send(input bit wr, input int addr, input logic [7:0] wd,
                      input logic [7:0] exp_rd, input bit exp_err, input bit push);
    int i;
    for (i = 0; i < 2 * REV; i++) begin
      @(negedge clk);
      if (req_ready === 1'b1) break;
    end
    if (i == 2 * REV) check("ready_timeout", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = ADDR_W'(addr);
    req_wdata = wd;
    acc_cyc   = cyc;
    if (push) exp_q.push_back('{rdata: exp_rd, err: exp_err});
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    int i;
    for (i = 0; i < LAT_MAX + 20; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    check("rsp_timeout", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic xact(input bit wr, input int addr, input logic [7:0] wd,
                      input logic [7:0] exp_rd, input bit exp_err);
    send(wr, addr, wd, exp_rd, exp_err, 1'b1);
    wait_rsp();
  endtask

  task automatic wait_bit_addr(input int val);
    int i;
    for (i = 0; i < 2 * REV; i++) begin
      @(posedge clk);
      #1;
      if (bit_addr == 10'(val)) break;
    end
    if (i == 2 * REV) check("bit_addr_timeout", 32'(bit_addr), 32'(val));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  int lat;
  int cnt0;
  int n_wait;

  initial begin
    reset     = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    repeat (3) @(negedge clk);
    // Reset state
    check("rst_line_in", 32'(line_in), 32'd0);
    check("rst_bit_addr", 32'(bit_addr), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
`ifdef DELAY_SCHED_CLEAR_EN
    check("rst_req_ready", 32'(req_ready), 32'd0);
    reset = 1'b0;
    // Clear revolution: ready stays low for exactly one revolution of posedges.
    n_wait = 0;
    while (n_wait < 2 * REV) begin
      @(posedge clk);
      n_wait++;
      #1;
      if (req_ready === 1'b1) break;
    end
    check("clear_ready_cycles", 32'(n_wait), 32'(REV));
    xact(1'b0, 7, 8'h00, 8'h00, 1'b0);
`else
    check("rst_req_ready", 32'(req_ready), 32'd1);
    reset = 1'b0;
`endif

    // Write addr 0 = 0x01: line_in high only during slot 0, for one slot's worth of clocks.
    ones_cnt = 0;
    ones_bad = 0;
    watch    = 1'b1;
    xact(1'b1, 0, 8'h01, 8'h00, 1'b0);
    watch    = 1'b0;
    check("wr0_ones_cycles", 32'(ones_cnt), 32'(BIT_CLKS));
    check("wr0_ones_off_slot0", 32'(ones_bad), 32'd0);

    // Write addr 3 = 0xA5, let it recirculate three revolutions, read back.
    xact(1'b1, 3, 8'hA5, 8'h00, 1'b0);
    repeat (3 * REV) @(negedge clk);
    xact(1'b0, 3, 8'h00, 8'hA5, 1'b0);
    xact(1'b0, 0, 8'h00, 8'h01, 1'b0);
    xact(1'b0, 4, 8'h00, 8'h00, 1'b0);
    xact(1'b0, 2, 8'h00, 8'h00, 1'b0);

    // Out-of-range addresses: error response in the cycle after accept.
    xact(1'b0, BITS / 8, 8'h00, 8'h00, 1'b1);
    check("err_latency", 32'(rsp_cyc - acc_cyc), 32'd1);
    xact(1'b1, 15, 8'hFF, 8'h00, 1'b1);
    xact(1'b0, 3, 8'h00, 8'hA5, 1'b0);

    // Read accepted mid-slot of its own base address waits a full revolution.
    wait_bit_addr(16);
    @(negedge clk);
    @(negedge clk);
    cnt0 = rsp_count;
    send(1'b0, 2, 8'h00, 8'h00, 1'b0, 1'b1);
    wait_rsp();
    lat = rsp_cyc - acc_cyc;
    check("wait_rev_lat_min", 32'(lat > int'(REV)), 32'd1);
    check("wait_rev_lat_max", 32'(lat <= int'(LAT_MAX)), 32'd1);
    repeat (20) @(negedge clk);
    check("single_rsp_pulse", 32'(rsp_count - cnt0), 32'd1);

    // Reset during a write transfer (idx 4) aborts it silently.
    wait_bit_addr(0);
    send(1'b1, 1, 8'hFF, 8'h00, 1'b0, 1'b0);
    wait_bit_addr(12);
    @(negedge clk);
    cnt0 = rsp_count;
    reset = 1'b1;
    #1;
    check("abort_line_in", 32'(line_in), 32'd0);
    check("abort_bit_addr", 32'(bit_addr), 32'd0);
    check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2 * REV) @(negedge clk);
    check("abort_no_rsp", 32'(rsp_count - cnt0), 32'd0);
    xact(1'b1, 5, 8'h3C, 8'h00, 1'b0);
    xact(1'b0, 5, 8'h00, 8'h3C, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global safety net in case a bounded wait is somehow bypassed.
  initial begin
    #(10 * 40000);
    $display("FAIL global_timeout: simulation exceeded its time limit, expected completion");
    $fatal(1, "timeout");
  end

endmodule
